// File: rtl/hit_judge_if.sv
// hit_judge_if: player-pad and judgement-pulse signals for hit_judge.
//   button, arrowEnter      : pad input and arrow-entered pulse (into the judge)
//   plus2, plus1, minus2    : registered one-cycle judgement pulses (out of the judge)
//   active                  : judgement window open (out of the judge)
interface hit_judge_if;
    logic button;
    logic arrowEnter;
    logic plus2;
    logic plus1;
    logic minus2;
    logic active;
    modport master (output button, arrowEnter, input plus2, plus1, minus2, active);
    modport slave  (input button, arrowEnter, output plus2, plus1, minus2, active);
endinterface

// File: rtl/hit_judge.sv
// hit_judge: timing-window judge for one arrow; grades a synchronized pad press as
// perfect (plus2), good (plus1) or miss (minus2).
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : hit_judge_if.slave (button, arrowEnter in; plus2, plus1, minus2, active out)
// Define HIT_JUDGE_STRAY_PENALTY_EN to penalise presses made while no arrow is pending.
module hit_judge #(
    parameter int unsigned EARLY_CYC   = 8,
    parameter int unsigned PERFECT_CYC = 4,
    parameter int unsigned LATE_CYC    = 8
) (
    input logic Clock,
    input logic Reset,
    hit_judge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EARLY, PERFECT, LATE} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    // sync[0], sync[1]: synchronizer; sync[2]: previous synced value for edge detection
    logic [2:0] sync;
    logic press, last, plus2_nx, plus1_nx, minus2_nx;
    assign press = sync[1] & ~sync[2];
    assign last = state == EARLY   ? cnt == 8'(EARLY_CYC - 1) :
                  state == PERFECT ? cnt == 8'(PERFECT_CYC - 1) :
                  state == LATE    ? cnt == 8'(LATE_CYC - 1) : 1'b0;
    assign bus.active = state != IDLE;
    always_comb begin
        state_nx  = state;
        plus2_nx  = 1'b0;
        plus1_nx  = 1'b0;
        minus2_nx = 1'b0;
        case (state)
            IDLE: begin
                // a press coinciding with arrowEnter is discarded
                if (bus.arrowEnter) state_nx = EARLY;
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
                else if (press) minus2_nx = 1'b1;
`endif
            end
            EARLY: begin
                if (press) begin
                    plus1_nx = 1'b1;
                    state_nx = IDLE;
                end else if (last) state_nx = PERFECT;
            end
            PERFECT: begin
                if (press) begin
                    plus2_nx = 1'b1;
                    state_nx = IDLE;
                end else if (last) state_nx = LATE;
            end
            default: begin
                // a press on the final late cycle beats the timeout
                if (press) begin
                    plus1_nx = 1'b1;
                    state_nx = IDLE;
                end else if (last) begin
                    minus2_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sync       <= '0;
            bus.plus2  <= 1'b0;
            bus.plus1  <= 1'b0;
            bus.minus2 <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
            sync       <= {sync[1:0], bus.button};
            bus.plus2  <= plus2_nx;
            bus.plus1  <= plus1_nx;
            bus.minus2 <= minus2_nx;
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: randomized and directed self-checking bench for hit_judge.
module tb_hit_judge;
    localparam int E = 8, P = 4, L = 8;
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
    localparam bit STRAY = 1'b1;
`else
    localparam bit STRAY = 1'b0;
`endif
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    hit_judge_if bus ();
    hit_judge #(.EARLY_CYC(E), .PERFECT_CYC(P), .LATE_CYC(L)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );
    always #5 Clock = ~Clock;

    int passes = 0, fails = 0;
    int cyc = 0, last_rst = -1, start = 0;
    bit hist [0:8191];
    bit armed = 1'b0;
    bit e_p2, e_p1, e_m2, e_act;

    // button value seen during cycle c, with everything up to the last reset treated as low
    function automatic bit btn_at(input int c);
        return (c >= 0 && c > last_rst) ? hist[c] : 1'b0;
    endfunction

    // a press is recognised two cycles after the pad's rising edge
    function automatic bit press_at(input int c);
        return btn_at(c - 2) & ~btn_at(c - 3);
    endfunction

    // drive one cycle, advance the reference model, and land #1 after the next edge
    task automatic step(input bit r, input bit a, input bit b);
        bit pr, n2, n1, nm;
        int off;
        Reset = r;
        bus.arrowEnter = a;
        bus.button = b;
        hist[cyc] = b;
        if (r) last_rst = cyc;
        pr = press_at(cyc);
        n2 = 0; n1 = 0; nm = 0;
        if (r) armed = 0;
        else if (armed) begin
            off = cyc - start;
            if (pr) begin
                if (off > E && off <= E + P) n2 = 1; else n1 = 1;
                armed = 0;
            end else if (off == E + P + L) begin
                nm = 1;
                armed = 0;
            end
        end else if (a) begin
            armed = 1;
            start = cyc;
        end else if (pr && STRAY) nm = 1;
        @(posedge Clock);
        #1;
        cyc++;
        e_p2 = n2; e_p1 = n1; e_m2 = nm; e_act = armed;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, k[0], 1);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== 4'b0000) begin
                fails++;
                $display("FAIL reset cyc=%0d got=%b exp=0000", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active});
            end else passes++;
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
        end
    endtask

    // arrowEnter at 0, press event at 10 -> plus2 at 11 only
    task automatic test_perfect();
        int p2_cnt = 0;
        bit hit11 = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, k == 0, k == 8 || k == 9);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL perfect cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
            p2_cnt += int'(bus.plus2);
            if (k + 1 == 11) hit11 = bus.plus2 & ~bus.active;
        end
        if (!(hit11 && p2_cnt == 1)) begin
            fails++;
            $display("FAIL perfect_at_11 got hit11=%0d count=%0d exp hit11=1 count=1", hit11, p2_cnt);
        end else passes++;
    endtask

    // press at 3 -> plus1 at 4; second press at 6 is stray
    task automatic test_early();
        bit hit4 = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, k == 0, k == 1 || k == 4);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL early cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
            if (k + 1 == 4) hit4 = bus.plus1;
            if (k + 1 == 7 && bus.minus2 !== STRAY) begin
                fails++;
                $display("FAIL stray_at_7 got=%b exp=%b", bus.minus2, STRAY);
            end else if (k + 1 == 7) passes++;
        end
        if (!hit4) begin
            fails++;
            $display("FAIL plus1_at_4 got=0 exp=1");
        end else passes++;
    endtask

    // timeout -> minus2 at 21; press at 20 -> plus1 at 21
    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 26; k++) begin
                step(0, k == 0, v == 1 && k == 18);
                if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                    fails++;
                    $display("FAIL timeout%0d cyc=%0d got=%b exp=%b", v, cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
                end else passes++;
                if (k + 1 == 20 && bus.active !== 1'b1) begin
                    fails++;
                    $display("FAIL active_at_20 got=%b exp=1", bus.active);
                end
                if (k + 1 == 21 && {bus.plus1, bus.minus2, bus.active} !== (v == 1 ? 3'b100 : 3'b010)) begin
                    fails++;
                    $display("FAIL judge_at_21 v=%0d got=%b exp=%b", v, {bus.plus1, bus.minus2, bus.active}, (v == 1 ? 3'b100 : 3'b010));
                end else if (k + 1 == 21) passes++;
            end
        end
    endtask

    // reset at 5 abandons the arrow
    task automatic test_reset_mid();
        for (int k = 0; k < 31; k++) begin
            step(k == 5, k == 0, k == 3);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
            if (k + 1 >= 6 && {bus.plus2, bus.plus1, bus.minus2, bus.active} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=0000", k + 1, {bus.plus2, bus.plus1, bus.minus2, bus.active});
            end
        end
    endtask

    // button held 40 cycles across two arrows
    task automatic test_held();
        int judged = 0;
        bit m46 = 0;
        for (int k = 0; k < 52; k++) begin
            step(0, k == 0 || k == 25, k >= 2 && k < 42);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL held cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
            judged += int'(bus.plus2) + int'(bus.plus1) + int'(bus.minus2);
            if (k + 1 == 46) m46 = bus.minus2;
        end
        if (!(judged == 2 && m46)) begin
            fails++;
            $display("FAIL held_summary got judged=%0d m46=%0d exp judged=2 m46=1", judged, m46);
        end else passes++;
    endtask

    // judgement then immediate re-arm with a coincident press that must be discarded
    task automatic test_back_to_back();
        for (int k = 0; k < 32; k++) begin
            step(0, k == 0 || k == 6, k == 1 || k == 4);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
            if (k + 1 == 27 && bus.minus2 !== 1'b1) begin
                fails++;
                $display("FAIL b2b_timeout_at_27 got=%b exp=1", bus.minus2);
            end
        end
    endtask

    task automatic test_random();
        bit b = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, b);
            if ({bus.plus2, bus.plus1, bus.minus2, bus.active} !== {e_p2, e_p1, e_m2, e_act}) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {bus.plus2, bus.plus1, bus.minus2, bus.active}, {e_p2, e_p1, e_m2, e_act});
            end else passes++;
        end
    endtask

    task automatic settle();
        for (int k = 0; k < 4; k++) step(0, 0, 0);
    endtask

    initial begin
        bus.button = 1'b0;
        bus.arrowEnter = 1'b0;
        test_reset();
        test_perfect();
        settle();
        test_early();
        settle();
        test_timeout();
        settle();
        test_reset_mid();
        settle();
        test_held();
        settle();
        test_back_to_back();
        settle();
        test_random();
        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end
endmodule
